// File: rtl/ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg.sv
// rtl/ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg.sv - read side of the last-stage dispatch-rotate ping-pong buffer
// Reads completed halves row by row, un-rotates each row in two registered steps and returns free tokens.
module ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg #(
    parameter int BANK_NB = 4,
    parameter int OP_W    = 32,
    parameter int DEPTH   = 8,
    parameter int RAM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     a_rst,
    input  logic                     wr_buf_done,
    output logic                     rd_buf_free,
    output logic                     ram_rd_en,
    output logic [$clog2(DEPTH):0]   ram_rd_add,
    input  logic [BANK_NB*OP_W-1:0]  ram_rd_data,
    output logic [BANK_NB*OP_W-1:0]  out_data,
    output logic                     out_avail,
    output logic                     out_sob,
    output logic                     out_eob,
    output logic                     error
);
    localparam int RW = $clog2(DEPTH);
    localparam int SW = $clog2(BANK_NB);
    localparam int DW = BANK_NB * OP_W;

    typedef enum logic {IDLE, READ} state_t;

    state_t        state;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          buf_id;
    logic [RW-1:0] row;
    logic          consume;
    logic [SW-1:0] row_shift;

    logic          tv   [RAM_LAT];
    logic [SW-1:0] tsh  [RAM_LAT];
    logic          tsob [RAM_LAT];
    logic          teob [RAM_LAT];

    logic          s1_v, s1_sob, s1_eob, s1_fine;
    logic [DW-1:0] s1_data;

    // out[p] = in[(p + amt) mod BANK_NB]
    function automatic logic [DW-1:0] rot(input logic [DW-1:0] d, input int amt);
        logic [DW-1:0] res;
        res = '0;
        for (int p = 0; p < BANK_NB; p++)
            res[p*OP_W +: OP_W] = d[((p + amt) % BANK_NB)*OP_W +: OP_W];
        return res;
    endfunction

    assign ram_rd_en  = (state == READ);
    assign ram_rd_add = {buf_id, row};
    assign consume    = (state == READ) && (row == RW'(DEPTH - 1));
    assign row_shift  = SW'(int'(row) % BANK_NB);

    always_comb begin
        count_next = count;
        error      = 1'b0;
        if (wr_buf_done && !consume) begin
            if (count == 2'd2) error = 1'b1;
            else               count_next = count + 2'd1;
        end else if (!wr_buf_done && consume) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state       <= IDLE;
            count       <= 2'd0;
            buf_id      <= 1'b0;
            row         <= '0;
            rd_buf_free <= 1'b0;
        end else begin
            count       <= count_next;
            rd_buf_free <= consume;
            case (state)
                IDLE: begin
                    if (count_next != 2'd0) state <= READ;
                end
                READ: begin
                    if (consume) begin
                        row    <= '0;
                        buf_id <= ~buf_id;
                        // back-to-back halves when another token is already waiting
                        if (count_next == 2'd0) state <= IDLE;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row tags ride alongside the RAM read so they land with the data.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                tv[i]   <= 1'b0;
                tsh[i]  <= '0;
                tsob[i] <= 1'b0;
                teob[i] <= 1'b0;
            end
        end else begin
            tv[0]   <= (state == READ);
            tsh[0]  <= row_shift;
            tsob[0] <= (state == READ) && (row == '0);
            teob[0] <= consume;
            for (int i = 1; i < RAM_LAT; i++) begin
                tv[i]   <= tv[i-1];
                tsh[i]  <= tsh[i-1];
                tsob[i] <= tsob[i-1];
                teob[i] <= teob[i-1];
            end
        end
    end

    // Coarse rotation (even part of the shift) then the odd single-bank step.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            s1_v      <= 1'b0;
            s1_sob    <= 1'b0;
            s1_eob    <= 1'b0;
            s1_fine   <= 1'b0;
            s1_data   <= '0;
            out_avail <= 1'b0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_data  <= '0;
        end else begin
            s1_v   <= tv[RAM_LAT-1];
            s1_sob <= tv[RAM_LAT-1] && tsob[RAM_LAT-1];
            s1_eob <= tv[RAM_LAT-1] && teob[RAM_LAT-1];
            if (tv[RAM_LAT-1]) begin
                s1_data <= rot(ram_rd_data, int'(tsh[RAM_LAT-1]) & ~1);
                s1_fine <= tsh[RAM_LAT-1][0];
            end
            out_avail <= s1_v;
            out_sob   <= s1_v && s1_sob;
            out_eob   <= s1_v && s1_eob;
            if (s1_v) out_data <= rot(s1_data, int'(s1_fine));
        end
    end
endmodule

// File: tb/tb_ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg.sv
// tb/tb_ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg.sv - directed scoreboard bench for the last-stage read PCG
module tb_ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg;
    localparam int BANK_NB = 4;
    localparam int OP_W    = 32;
    localparam int DEPTH   = 8;
    localparam int RAM_LAT = 1;
    localparam int DW      = BANK_NB * OP_W;
    localparam int AW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          a_rst;
    logic          wr_buf_done;
    logic          rd_buf_free;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_add;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] out_data;
    logic          out_avail, out_sob, out_eob, error;

    typedef struct {
        logic [DW-1:0] data;
        logic          sob;
        logic          eob;
    } exp_t;

    exp_t          exp_q[$];
    int            rd_c[$], rd_a[$], av_c[$], fr_c[$], er_c[$];
    logic [DW-1:0] av_d[$];
    logic          av_s[$], av_e[$];
    int            cyc = 0;
    int            base = 0;
    int            checks = 0;
    int            errors = 0;
    logic          exp_buf = 1'b0;

    ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg #(
        .BANK_NB(BANK_NB), .OP_W(OP_W), .DEPTH(DEPTH), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk(clk), .a_rst(a_rst), .wr_buf_done(wr_buf_done), .rd_buf_free(rd_buf_free),
        .ram_rd_en(ram_rd_en), .ram_rd_add(ram_rd_add), .ram_rd_data(ram_rd_data),
        .out_data(out_data), .out_avail(out_avail), .out_sob(out_sob), .out_eob(out_eob),
        .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Writer stored coefficient p of row r in bank (p + r) mod 4.
    function automatic logic [OP_W-1:0] ram_word(input logic [AW-1:0] a, input int b);
        int r;
        int bf;
        r  = int'(a[AW-2:0]);
        bf = int'(a[AW-1]);
        return OP_W'(256*bf + 16*r + ((b - r) & (BANK_NB - 1)));
    endfunction

    always @(posedge clk)
        if (ram_rd_en)
            for (int b = 0; b < BANK_NB; b++)
                ram_rd_data[b*OP_W +: OP_W] <= ram_word(ram_rd_add, b);

    always @(negedge clk) begin
        if (ram_rd_en) begin
            rd_c.push_back(cyc - base);
            rd_a.push_back(int'(ram_rd_add));
        end
        if (out_avail) begin
            av_c.push_back(cyc - base);
            av_d.push_back(out_data);
            av_s.push_back(out_sob);
            av_e.push_back(out_eob);
        end
        if (rd_buf_free) fr_c.push_back(cyc - base);
        if (error)       er_c.push_back(cyc - base);
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_half(input logic bf);
        exp_t e;
        for (int r = 0; r < DEPTH; r++) begin
            for (int p = 0; p < BANK_NB; p++)
                e.data[p*OP_W +: OP_W] = OP_W'(256*int'(bf) + 16*r + p);
            e.sob = (r == 0);
            e.eob = (r == DEPTH - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; that cycle becomes relative cycle 0.
    task automatic run_scn(input int n, input logic [31:0] done_m, input logic [31:0] ovf_m);
        rd_c.delete(); rd_a.delete(); av_c.delete(); av_d.delete();
        av_s.delete(); av_e.delete(); fr_c.delete(); er_c.delete();
        base = cyc;
        for (int k = 0; k < n; k++) begin
            wr_buf_done = done_m[k];
            if (done_m[k] && !ovf_m[k]) begin
                push_half(exp_buf);
                exp_buf = ~exp_buf;
            end
            @(posedge clk); #1;
        end
        wr_buf_done = 1'b0;
    endtask

    task automatic proc_sb();
        exp_t e;
        for (int i = 0; i < av_d.size(); i++) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", av_d[i], e.data);
                chk("sb_sob", DW'(av_s[i]), DW'(e.sob));
                chk("sb_eob", DW'(av_e[i]), DW'(e.eob));
            end
        end
        chk("sb_leftover", exp_q.size(), 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd_en"}, DW'(ram_rd_en), 0);
        chk({tag, "_rd_add"}, DW'(ram_rd_add), 0);
        chk({tag, "_avail"}, DW'(out_avail), 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_sob_eob"}, DW'({out_sob, out_eob}), 0);
        chk({tag, "_free_err"}, DW'({rd_buf_free, error}), 0);
    endtask

    initial begin
        logic [DW-1:0] row5;
        a_rst = 1'b1;
        wr_buf_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        a_rst = 1'b0;
        @(posedge clk); #1;

        // single half
        run_scn(14, 32'h1, 32'h0);
        chk("s1_rd_count", rd_c.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("s1_rd_cycle", rd_c[i], 1 + i);
            chk("s1_rd_addr", rd_a[i], i);
        end
        chk("s1_av_count", av_c.size(), 8);
        chk("s1_av_first", av_c[0], 4);
        chk("s1_av_last", av_c[7], 11);
        chk("s1_free_count", fr_c.size(), 1);
        chk("s1_free_cycle", fr_c[0], 9);
        chk("s1_err_count", er_c.size(), 0);
        proc_sb();

        // second half lands in buffer 1 and checks the rotation
        run_scn(14, 32'h1, 32'h0);
        chk("s2_rd_count", rd_c.size(), 8);
        for (int i = 0; i < 8; i++) chk("s2_rd_addr", rd_a[i], 8 + i);
        for (int p = 0; p < BANK_NB; p++) row5[p*OP_W +: OP_W] = OP_W'(256 + 80 + p);
        chk("s2_row5", av_d[5], row5);
        proc_sb();

        // two tokens, back-to-back halves
        run_scn(22, 32'h5, 32'h0);
        chk("s3_rd_count", rd_c.size(), 16);
        chk("s3_av_count", av_c.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("s3_rd_cycle", rd_c[i], 1 + i);
            chk("s3_rd_addr", rd_a[i], i);
            chk("s3_av_cycle", av_c[i], 4 + i);
        end
        chk("s3_free_count", fr_c.size(), 2);
        chk("s3_free_0", fr_c[0], 9);
        chk("s3_free_1", fr_c[1], 17);
        proc_sb();

        // overflow on the third token
        run_scn(30, 32'h7, 32'h4);
        chk("s4_err_count", er_c.size(), 1);
        chk("s4_err_cycle", er_c[0], 2);
        chk("s4_rd_count", rd_c.size(), 16);
        chk("s4_free_count", fr_c.size(), 2);
        chk("s4_idle_end", DW'(ram_rd_en), 0);
        proc_sb();

        // token arriving with the last-row issue
        run_scn(22, 32'h101, 32'h0);
        chk("s5_rd_count", rd_c.size(), 16);
        chk("s5_rd8_cycle", rd_c[8], 9);
        chk("s5_rd8_addr", rd_a[8], 8);
        chk("s5_rd15_cycle", rd_c[15], 16);
        chk("s5_err_count", er_c.size(), 0);
        proc_sb();

        // asynchronous reset in the middle of a half
        run_scn(5, 32'h1, 32'h0);
        a_rst = 1'b1;
        #2;
        chk_zero_outputs("s6_async");
        @(posedge clk); #1;
        a_rst = 1'b0;
        exp_q.delete();
        exp_buf = 1'b0;
        run_scn(12, 32'h0, 32'h0);
        chk("s6_quiet_rd", rd_c.size(), 0);
        chk("s6_quiet_av", av_c.size(), 0);
        chk("s6_quiet_free", fr_c.size(), 0);
        run_scn(14, 32'h1, 32'h0);
        chk("s6_restart_cycle", rd_c[0], 1);
        chk("s6_restart_addr", rd_a[0], 0);
        chk("s6_free_cycle", fr_c[0], 9);
        proc_sb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg.md
Name: ntt_core_wmm_dispatch_rotate_last_stage_rd_pcg

Overview:
- Read side of the last-stage dispatch-rotate ping-pong buffer in the NTT core WMM.
- The last-stage write PCG stores each row rotated across banks and signals each completed half-buffer.
- This block reads completed halves row by row, un-rotates each row with a 2-stage registered mux, and streams rows to the next stage.
- It returns a buffer-free token to the writer as each half is released.

Parameters:
BANK_NB, 4, number of RAM banks = coefficients per row (power of 2, >=2)
OP_W, 32, coefficient width in bits
DEPTH, 8, rows per half-buffer (power of 2, >=2)
RAM_LAT, 1, RAM read latency in cycles (>=1)

Ports:
clk  in  1  clock
a_rst  in  1  asynchronous reset, active-high
wr_buf_done  in  1  single-cycle pulse from write PCG: one half-buffer is complete
rd_buf_free  out  1  single-cycle pulse to write PCG: one half-buffer is released
ram_rd_en  out  1  read enable, common to all banks
ram_rd_add  out  $clog2(DEPTH)+1  read address {buf_id, row}, common to all banks
ram_rd_data  in  BANK_NB*OP_W  bank b data on bits [b*OP_W +: OP_W], valid RAM_LAT cycles after ram_rd_en
out_data  out  BANK_NB*OP_W  un-rotated row; coefficient p on bits [p*OP_W +: OP_W]
out_avail  out  1  out_data valid this cycle
out_sob  out  1  with out_avail: first row of a half-buffer
out_eob  out  1  with out_avail: last row of a half-buffer
error  out  1  single-cycle pulse on token overflow

Behaviour:
- Reset: every output is 0; token count = 0; buf_id = 0; row = 0; FSM in IDLE; all in-flight valid bits cleared.
- Reset mid-operation discards in-flight data. No out_avail and no rd_buf_free are produced for the interrupted buffer.
- Token counter, range 0..2, updated every cycle as +wr_buf_done minus consume:
  - consume = 1 in the cycle the last row of a half is issued.
  - wr_buf_done and consume in the same cycle: count unchanged.
  - wr_buf_done with count == 2 and no consume: count stays 2, error pulses.
- FSM IDLE:
  - Count > 0: go to READ next cycle.
  - wr_buf_done arriving while count == 0: READ starts the cycle after the pulse.
- FSM READ:
  - Each cycle: ram_rd_en = 1, ram_rd_add = {buf_id, row}, row increments.
  - At row == DEPTH-1: consume, toggle buf_id, row -> 0.
  - After the last row, stay in READ if the post-update count > 0 (back-to-back, no bubble); otherwise go to IDLE.
- rd_buf_free pulses exactly 1 cycle after the ram_rd_en of a half's last row.
- Rotation rule: the writer placed coefficient p of row r in bank (p + r) mod BANK_NB. Therefore out[p] = ram_rd_data bank ((p + r) mod BANK_NB), where r is the row index (buf_id excluded).
- Row index and sob/eob tags travel in a shift pipe aligned with the RAM latency.
- Pipeline: S0 = RAM data arrival, S0_S1 register, S1_S2 register.
  - Output latency is ram_rd_en -> out_avail = RAM_LAT + 2 cycles, fixed.
  - out_sob is set for row 0 and out_eob for row DEPTH-1.
  - out_data is held (not cleared) when out_avail = 0.
- No backpressure: the downstream stage always accepts.
- Throughput: 1 row per cycle while tokens are available.

Test Plan:
1. Reset, then a single wr_buf_done pulse at cycle 0 (BANK_NB=4, DEPTH=8, RAM_LAT=1) -> ram_rd_en high cycles 1..8 with addresses 0..7; out_avail cycles 4..11; out_sob at cycle 4, out_eob at cycle 11; rd_buf_free at cycle 9; buf_id = 1 afterwards.
2. Rotation check with the RAM model storing bank b, row r = 16*r + ((b - r) mod 4) -> every output row r is {16r+3, 16r+2, 16r+1, 16r} (p = 0 in the LSBs); row 5 reads banks 1,2,3,0.
3. Two wr_buf_done pulses at cycles 0 and 2 -> 16 consecutive ram_rd_en cycles, addresses 0..7 then 8..15, no bubble; rd_buf_free at cycles 9 and 17; out_avail continuous for 16 cycles.
4. wr_buf_done at cycles 0, 1 and 2 (count already 2 at cycle 2, no consume) -> error pulses at cycle 2 only; exactly 2 halves are read; count is 0 at the end.
5. wr_buf_done coincident with the last-row issue (cycle 8 of scenario 1) -> count stays 1; READ continues at address 8 in cycle 9 with no gap; no error.
6. a_rst asserted at cycle 5 of scenario 1 -> all outputs 0 immediately; after release there are no out_avail and no rd_buf_free until a new wr_buf_done, which reads from address 0.
